// File: rtl/calc_entry_pkg.sv
// Purpose : shared key codes, entry-state encoding and operand width helper
//           for the calculator operand-entry block.
// Latency : n/a (package).
// Backpressure: n/a (package).
package calc_entry_pkg;

    localparam logic [4:0] KEY_OP_FIRST = 5'd10;
    localparam logic [4:0] KEY_OP_LAST  = 5'd13;
    localparam logic [4:0] KEY_EQ       = 5'd14;
    localparam logic [4:0] KEY_SIGN     = 5'd15;
    localparam logic [4:0] KEY_CLR      = 5'd16;
    localparam logic [4:0] KEY_BS       = 5'd18;

    typedef enum logic [1:0] {
        ENTER_A  = 2'd0,
        WAIT_B   = 2'd1,
        ENTER_B  = 2'd2,
        SHOW_RES = 2'd3
    } entry_state_t;

    // Signed BCD operand width: sign bit plus four bits per digit.
    function automatic int ow(input int digits);
        return 4 * digits + 1;
    endfunction

endpackage

// File: rtl/key_press_detect.sv
// Purpose : registers the decoded key and flags a new press (idle -> key edge).
// Latency : key sampled at edge N appears on o_key_q; o_press valid in the cycle after edge N.
// Backpressure: none; every key change is sampled every cycle.
//
// Ports:
//   clk, rst_n   clock / async active-low reset
//   i_key_code   decoded key code from the keypad decoder
//   o_key_q      registered key code
//   o_press      high when o_key_q is a key and the previous sample was idle
module key_press_detect #(
    parameter logic [4:0] NO_KEY = 5'd17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] i_key_code,
    output logic [4:0] o_key_q,
    output logic       o_press
);

    logic [4:0] r_key_q;
    logic [4:0] r_key_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_q    <= NO_KEY;
            r_key_prev <= NO_KEY;
        end else begin
            r_key_q    <= i_key_code;
            r_key_prev <= r_key_q;
        end
    end

    // A key-to-key change without an idle sample in between is not a press.
    assign o_press = (r_key_q != NO_KEY) && (r_key_prev == NO_KEY);
    assign o_key_q = r_key_q;

endmodule

// File: rtl/calc_operand_entry.sv
// Purpose : keypad-to-signed-BCD operand entry (A, B, opcode) with chaining from ALU result.
// Latency : key sampled at edge N acts at edge N+1; key_strobe high in the cycle after edge N+1.
// Backpressure: none; one action per press, held keys act once.
//
// Ports:
//   clk, rst_n   clock / async active-low reset
//   key_code     decoded key (0-9 digit, 10-13 op, 14 eq, 15 sign, 16 clear, 18 backspace)
//   result       signed BCD result from the ALU, loaded into A on equals/chained op
//   operand_a/b  signed BCD operands (MSB = sign, 1 = negative)
//   opcode       ALU operation code (10-13)
//   entry_state  current entry phase, used for display selection
//   digit_ovf    sticky flag: a digit was dropped because the operand was full
//   key_strobe   one-cycle pulse per accepted press
// Optional feature: define CALC_ENTRY_BACKSPACE_EN to build the backspace key (18).
module calc_operand_entry
    import calc_entry_pkg::*;
#(
    parameter int         DIGITS = 5,
    parameter logic [4:0] NO_KEY = 5'd17,
    localparam int        OW     = calc_entry_pkg::ow(DIGITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [4:0]    key_code,
    input  logic [OW-1:0] result,
    output logic [OW-1:0] operand_a,
    output logic [OW-1:0] operand_b,
    output logic [3:0]    opcode,
    output logic [1:0]    entry_state,
    output logic          digit_ovf,
    output logic          key_strobe
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam int DW = 4 * DIGITS;

    logic [4:0]    w_key_q;
    logic          w_press;

    entry_state_t  r_state,  w_state_nxt;
    logic [OW-1:0] r_a,      w_a_nxt;
    logic [OW-1:0] r_b,      w_b_nxt;
    logic [3:0]    r_op,     w_op_nxt;
    logic [CW-1:0] r_cnt,    w_cnt_nxt;
    logic          r_ovf,    w_ovf_nxt;
    logic          r_strobe, w_strobe_nxt;

    key_press_detect #(.NO_KEY(NO_KEY)) u_press (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_key_code (key_code),
        .o_key_q    (w_key_q),
        .o_press    (w_press)
    );

    logic          w_is_digit;
    logic          w_is_op;
    logic          w_is_bs;
    logic          w_key_valid;
    logic [3:0]    w_d;
    logic          w_full;
    logic [CW-1:0] w_cnt_app;
    logic [CW-1:0] w_cnt_first;

    assign w_d        = w_key_q[3:0];
    assign w_is_digit = (w_key_q < KEY_OP_FIRST);
    assign w_is_op    = (w_key_q >= KEY_OP_FIRST) && (w_key_q <= KEY_OP_LAST);
`ifdef CALC_ENTRY_BACKSPACE_EN
    assign w_is_bs    = (w_key_q == KEY_BS);
`else
    assign w_is_bs    = 1'b0;
`endif
    assign w_key_valid = (w_key_q <= KEY_CLR) || w_is_bs;

    assign w_full      = (r_cnt == CW'(DIGITS));
    // Leading zeros on an empty operand do not consume a digit slot.
    assign w_cnt_app   = ((r_cnt == '0) && (w_d == 4'd0)) ? r_cnt : r_cnt + CW'(1);
    assign w_cnt_first = CW'(w_d != 4'd0);

    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_op_nxt     = r_op;
        w_cnt_nxt    = r_cnt;
        w_ovf_nxt    = r_ovf;
        w_strobe_nxt = 1'b0;

        if (w_press && w_key_valid) begin
            w_strobe_nxt = 1'b1;
            if (w_key_q == KEY_CLR) begin
                w_a_nxt     = '0;
                w_b_nxt     = '0;
                w_op_nxt    = '0;
                w_cnt_nxt   = '0;
                w_ovf_nxt   = 1'b0;
                w_state_nxt = ENTER_A;
            end else begin
                unique case (r_state)
                    ENTER_A: begin
                        if (w_is_digit) begin
                            if (w_full) begin
                                w_ovf_nxt = 1'b1;
                            end else begin
                                w_a_nxt   = {r_a[OW-1], r_a[DW-5:0], w_d};
                                w_cnt_nxt = w_cnt_app;
                            end
                        end else if (w_is_op) begin
                            w_op_nxt    = w_key_q[3:0];
                            w_state_nxt = WAIT_B;
                        end else if (w_key_q == KEY_SIGN) begin
                            w_a_nxt[OW-1] = ~r_a[OW-1];
                        end else if (w_is_bs && (r_cnt != '0)) begin
                            w_a_nxt   = {r_a[OW-1], 4'd0, r_a[DW-1:4]};
                            w_cnt_nxt = r_cnt - CW'(1);
                        end
                    end
                    WAIT_B: begin
                        if (w_is_digit) begin
                            // First digit of B replaces the digits; a sign toggled while waiting is kept.
                            w_b_nxt     = {r_b[OW-1], {(DW-4){1'b0}}, w_d};
                            w_cnt_nxt   = w_cnt_first;
                            w_state_nxt = ENTER_B;
                        end else if (w_is_op) begin
                            w_op_nxt = w_key_q[3:0];
                        end else if (w_key_q == KEY_SIGN) begin
                            w_b_nxt[OW-1] = ~r_b[OW-1];
                        end
                    end
                    ENTER_B: begin
                        if (w_is_digit) begin
                            if (w_full) begin
                                w_ovf_nxt = 1'b1;
                            end else begin
                                w_b_nxt   = {r_b[OW-1], r_b[DW-5:0], w_d};
                                w_cnt_nxt = w_cnt_app;
                            end
                        end else if (w_is_op) begin
                            // Chained operation: the pending result becomes the new A.
                            w_a_nxt     = result;
                            w_b_nxt     = '0;
                            w_cnt_nxt   = '0;
                            w_op_nxt    = w_key_q[3:0];
                            w_state_nxt = WAIT_B;
                        end else if (w_key_q == KEY_EQ) begin
                            w_a_nxt     = result;
                            w_b_nxt     = '0;
                            w_cnt_nxt   = '0;
                            w_state_nxt = SHOW_RES;
                        end else if (w_key_q == KEY_SIGN) begin
                            w_b_nxt[OW-1] = ~r_b[OW-1];
                        end else if (w_is_bs && (r_cnt != '0)) begin
                            w_b_nxt   = {r_b[OW-1], 4'd0, r_b[DW-1:4]};
                            w_cnt_nxt = r_cnt - CW'(1);
                        end
                    end
                    SHOW_RES: begin
                        if (w_is_digit) begin
                            w_a_nxt     = {1'b0, {(DW-4){1'b0}}, w_d};
                            w_b_nxt     = '0;
                            w_cnt_nxt   = w_cnt_first;
                            w_state_nxt = ENTER_A;
                        end else if (w_is_op) begin
                            w_op_nxt    = w_key_q[3:0];
                            w_state_nxt = WAIT_B;
                        end else if (w_key_q == KEY_SIGN) begin
                            w_a_nxt[OW-1] = ~r_a[OW-1];
                        end
                    end
                    default: w_state_nxt = ENTER_A;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ENTER_A;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_op     <= w_op_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ovf    <= w_ovf_nxt;
            r_strobe <= w_strobe_nxt;
        end
    end

    assign operand_a   = r_a;
    assign operand_b   = r_b;
    assign opcode      = r_op;
    assign entry_state = r_state;
    assign digit_ovf   = r_ovf;
    assign key_strobe  = r_strobe;

endmodule
